reg_bank: RTL
=============

# reg_bank

Parametrised 6502 register bank holding the CPU's user-visible registers (A, X, Y, SP by default) in one block, replacing individually instantiated single registers. One write/modify port supports load, increment and decrement. Two combinational read ports, registered N/Z flags, a wrap pulse, and per-register valid bits are provided. Sits between the instruction decoder/ALU and the datapath muxes.

## Interface
- BIT_WIDTH, 8, width of every register
- NUM_REGS, 4, number of registers; index 3 is SP when NUM_REGS ≥ 4
- RESET_VECTOR, {BIT_WIDTH{1'b0}}, reset value of all registers except SP
- SP_RESET_VECTOR, 8'hFD, reset value of SP (index 3)
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- op  in  2  operation: 00 HOLD, 01 LOAD, 10 INC, 11 DEC
- wsel  in  $clog2(NUM_REGS)  target register for op
- din  in  BIT_WIDTH  load data
- rsel_a, rsel_b  in  $clog2(NUM_REGS)  read-port selects
- rdata_a, rdata_b  out  BIT_WIDTH  combinational read data
- valid  out  NUM_REGS  bit i set once register i has been written since reset
- flag_n  out  1  MSB of last written result
- flag_z  out  1  last written result == 0
- wrap  out  1  one-cycle pulse: INC from all-ones or DEC from zero

## Operation
- LOAD: reg[wsel] ← din. INC: reg[wsel] ← reg[wsel]+1 mod 2^BIT_WIDTH. DEC: reg[wsel] ← reg[wsel]−1 mod 2^BIT_WIDTH. HOLD: no change.
- Every non-HOLD op with legal wsel sets valid[wsel], updates flag_n/flag_z from the new value.
- wrap asserts for exactly the cycle after INC of all-ones (result 0) or DEC of 0 (result all-ones); otherwise 0, including on HOLD/LOAD.
- wsel ≥ NUM_REGS: op ignored entirely (no register, flag, valid, or wrap change).
- Reads are combinational from stored contents; out-of-range rsel returns 0.
- Reset values: registers = RESET_VECTOR (SP = SP_RESET_VECTOR), valid = 0, flag_n = 0, flag_z = 1, wrap = 0.

## Timing
- Write latency 1: op sampled at rising edge; new value visible on rdata the same edge +δ.
- Flags and wrap are registered and valid in the same cycle as the new register value.
- Back-to-back ops on the same register chain correctly (INC,INC → +2 after two edges).
- reset asserted mid-operation: outputs go to reset values asynchronously; op on the deasserting edge is not executed if reset is still high at that edge.
- Deassertion is synchronous to the design's clk by upstream convention; no internal synchroniser.

## Configuration
- REG_BANK_BYPASS_EN defined: when op ≠ HOLD, wsel legal and rsel_x == wsel, rdata_x returns the next value (din, +1, or −1) in the same cycle.
- Not defined: rdata_x always returns stored value; caller sees new value one cycle later.

## Structure
- Shared package reg_bank_pkg: op encodings (OP_HOLD, OP_LOAD, OP_INC, OP_DEC), register indices (REG_A=0, REG_X=1, REG_Y=2, REG_SP=3), default BIT_WIDTH and SP reset constant.
- One sub-module reg_incdec: combinational next-value, N, Z and wrap from (op, current, din); instantiated once on the write path and reused by bypass logic.

## Test plan
- Reset, then read all: A/X/Y = 0x00, SP = 0xFD, valid = 0000, flag_z = 1, flag_n = 0.
- LOAD A ← 0x80 → rdata A = 0x80 next cycle, flag_n = 1, flag_z = 0, valid = 0001.
- LOAD X ← 0xFF, INC X → X = 0x00, flag_z = 1, wrap pulses one cycle; DEC X → X = 0xFF, wrap pulses, flag_n = 1.
- DEC SP three times from reset → 0xFA; wsel = out-of-range with LOAD 0x55 → no state, flag, or valid change.
- Bypass: with REG_BANK_BYPASS_EN, LOAD Y ← 0x42 and rsel_a = Y same cycle → rdata_a = 0x42 pre-edge; without macro → old value 0x00.
- Assert reset mid-INC burst on A (A = 0x05) → A = 0x00 immediately, valid = 0, no wrap.

Source files
------------

// File: rtl/reg_bank_pkg.sv
//==============================================================================
// Module   : reg_bank_pkg
// Brief    : Shared op encodings, register indices and defaults for reg_bank.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package reg_bank_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_DEC  = 2'b11
    } op_e;

    localparam int REG_A  = 0;
    localparam int REG_X  = 1;
    localparam int REG_Y  = 2;
    localparam int REG_SP = 3;

    localparam int         DEFAULT_BIT_WIDTH = 8;
    localparam logic [7:0] SP_RESET_DEFAULT  = 8'hFD;

    // Select width, kept at least one bit so a single-register bank still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_incdec.sv
//==============================================================================
// Module   : reg_incdec
// Brief    : Combinational next value, N, Z and wrap for one register op.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_incdec
    import reg_bank_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
    input  logic [1:0]           i_op,
    input  logic [BIT_WIDTH-1:0] i_cur,
    input  logic [BIT_WIDTH-1:0] i_din,
    output logic [BIT_WIDTH-1:0] o_next,
    output logic                 o_neg,
    output logic                 o_zero,
    output logic                 o_wrap
);

    always_comb begin
        o_next = i_cur;
        o_wrap = 1'b0;
        case (i_op)
            OP_LOAD: o_next = i_din;
            OP_INC: begin
                o_next = i_cur + BIT_WIDTH'(1);
                o_wrap = &i_cur;
            end
            OP_DEC: begin
                o_next = i_cur - BIT_WIDTH'(1);
                o_wrap = ~|i_cur;
            end
            default: ;
        endcase
    end

    assign o_neg  = o_next[BIT_WIDTH-1];
    assign o_zero = (o_next == '0);

endmodule

`default_nettype wire

// File: rtl/reg_bank.sv
//==============================================================================
// Module   : reg_bank
// Brief    : 6502 register bank (A/X/Y/SP) with load/inc/dec write port,
//            two read ports, N/Z flags, wrap pulse and per-register valid.
//            Optional same-cycle read bypass: define REG_BANK_BYPASS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                   BIT_WIDTH       = DEFAULT_BIT_WIDTH,
    parameter int                   NUM_REGS        = 4,
    parameter logic [BIT_WIDTH-1:0] RESET_VECTOR    = {BIT_WIDTH{1'b0}},
    parameter logic [BIT_WIDTH-1:0] SP_RESET_VECTOR = BIT_WIDTH'(SP_RESET_DEFAULT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [1:0]                       op,
    input  logic [sel_width(NUM_REGS)-1:0]   wsel,
    input  logic [BIT_WIDTH-1:0]             din,
    input  logic [sel_width(NUM_REGS)-1:0]   rsel_a,
    input  logic [sel_width(NUM_REGS)-1:0]   rsel_b,
    output logic [BIT_WIDTH-1:0]             rdata_a,
    output logic [BIT_WIDTH-1:0]             rdata_b,
    output logic [NUM_REGS-1:0]              valid,
    output logic                             flag_n,
    output logic                             flag_z,
    output logic                             wrap
);

    localparam int SEL_W    = sel_width(NUM_REGS);
    localparam int PAD_REGS = 2 ** SEL_W;

    logic [BIT_WIDTH-1:0] r_regs [NUM_REGS];
    logic [BIT_WIDTH-1:0] w_pad  [PAD_REGS];
    logic [NUM_REGS-1:0]  w_hit;
    logic [NUM_REGS-1:0]  r_valid;
    logic                 r_flag_n;
    logic                 r_flag_z;
    logic                 r_wrap;

    logic                 w_wr_en;
    logic [BIT_WIDTH-1:0] w_next;
    logic                 w_neg;
    logic                 w_zero;
    logic                 w_wrap;

    // Out-of-range selects must leave every piece of state untouched.
    assign w_wr_en = (op != OP_HOLD) && (int'(wsel) < NUM_REGS);

    reg_incdec #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_incdec (
        .i_op   (op),
        .i_cur  (w_pad[wsel]),
        .i_din  (din),
        .o_next (w_next),
        .o_neg  (w_neg),
        .o_zero (w_zero),
        .o_wrap (w_wrap)
    );

    // Unimplemented select codes read as zero through the padded view.
    generate
        for (genvar i = 0; i < PAD_REGS; i++) begin : g_reg
            if (i < NUM_REGS) begin : g_live
                localparam logic [BIT_WIDTH-1:0] c_RST_VALUE =
                    (i == REG_SP) ? SP_RESET_VECTOR : RESET_VECTOR;

                assign w_hit[i] = w_wr_en && (wsel == SEL_W'(i));
                assign w_pad[i] = r_regs[i];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_regs[i] <= c_RST_VALUE;
                    end else if (w_hit[i]) begin
                        r_regs[i] <= w_next;
                    end
                end
            end else begin : g_void
                assign w_pad[i] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_flag_n <= 1'b0;
            r_flag_z <= 1'b1;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= w_wr_en & w_wrap;
            if (w_wr_en) begin
                r_valid  <= r_valid | w_hit;
                r_flag_n <= w_neg;
                r_flag_z <= w_zero;
            end
        end
    end

`ifdef REG_BANK_BYPASS_EN
    assign rdata_a = (w_wr_en && (rsel_a == wsel)) ? w_next : w_pad[rsel_a];
    assign rdata_b = (w_wr_en && (rsel_b == wsel)) ? w_next : w_pad[rsel_b];
`else
    assign rdata_a = w_pad[rsel_a];
    assign rdata_b = w_pad[rsel_b];
`endif

    assign valid  = r_valid;
    assign flag_n = r_flag_n;
    assign flag_z = r_flag_z;
    assign wrap   = r_wrap;

endmodule

`default_nettype wire
